// File: rtl/upsampling_axi_pkg.sv
// Shared AXI4 write-path definitions for the upsampling IP: FSM state encoding
// and the protocol constants used on the AW/B channels.
package upsampling_axi_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        RESP = 2'd3
    } axi_wr_state_t;

    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

endpackage

// File: rtl/axi_burst_writer.sv
// AXI4 write master: turns one core write request into a single fixed-length
// INCR burst on AW/W/B and hands per-beat/end-of-burst strobes back to the core.
module axi_burst_writer
    import upsampling_axi_pkg::*;
#(
    parameter int DATA_WIDTH    = 64,
    parameter int ADDRESS_WIDTH = 32,
    parameter int BURST_LEN     = 16
) (
    input  logic                      clk,
    input  logic                      rst,

    input  logic                      write_init_i,
    input  logic [ADDRESS_WIDTH-1:0]  write_address_i,
    input  logic [DATA_WIDTH-1:0]     write_data_i,
    output logic                      write_next_o,
    output logic                      write_done_o,
    output logic                      write_error_o,
    output logic                      busy_o,

    output logic [ADDRESS_WIDTH-1:0]  m_axi_awaddr,
    output logic [7:0]                m_axi_awlen,
    output logic [2:0]                m_axi_awsize,
    output logic [1:0]                m_axi_awburst,
    output logic                      m_axi_awvalid,
    input  logic                      m_axi_awready,

    output logic [DATA_WIDTH-1:0]     m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0]   m_axi_wstrb,
    output logic                      m_axi_wlast,
    output logic                      m_axi_wvalid,
    input  logic                      m_axi_wready,

    input  logic [1:0]                m_axi_bresp,
    input  logic                      m_axi_bvalid,
    output logic                      m_axi_bready
);

    localparam int         STRB_WIDTH = DATA_WIDTH / 8;
    localparam logic [7:0] LAST_BEAT  = 8'(BURST_LEN - 1);
    localparam logic [2:0] BEAT_SIZE  = 3'($clog2(STRB_WIDTH));

    axi_wr_state_t state;
    logic [7:0]    beat_count;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= IDLE;
            beat_count    <= 8'd0;
            m_axi_awaddr  <= '0;
            write_done_o  <= 1'b0;
            write_error_o <= 1'b0;
        end else begin
            // NOTE: non-blocking defaults here make done/error one-cycle pulses;
            // the RESP branch below overrides them only on the B handshake.
            write_done_o  <= 1'b0;
            write_error_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (write_init_i) begin
                        m_axi_awaddr <= write_address_i;
                        beat_count   <= 8'd0;
                        state        <= ADDR;
                    end
                end
                ADDR: begin
                    if (m_axi_awready) state <= DATA;
                end
                DATA: begin
                    if (m_axi_wready) begin
                        beat_count <= beat_count + 8'd1;
                        if (beat_count == LAST_BEAT) state <= RESP;
                    end
                end
                RESP: begin
                    if (m_axi_bvalid) begin
                        write_done_o  <= 1'b1;
                        write_error_o <= (m_axi_bresp != AXI_RESP_OKAY);
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // VALID/READY come straight from the state register, so they cannot drop
    // before their handshake completes.
    assign m_axi_awvalid = (state == ADDR);
    assign m_axi_wvalid  = (state == DATA);
    assign m_axi_bready  = (state == RESP);
    assign busy_o        = (state != IDLE);

    assign m_axi_awlen   = LAST_BEAT;
    assign m_axi_awsize  = BEAT_SIZE;
    assign m_axi_awburst = AXI_BURST_INCR;

    assign m_axi_wdata   = write_data_i;
    assign m_axi_wstrb   = '1;
    assign m_axi_wlast   = (state == DATA) && (beat_count == LAST_BEAT);
    assign write_next_o  = m_axi_wvalid && m_axi_wready;

endmodule

// File: tb/tb_axi_burst_writer.sv
// Directed bench for axi_burst_writer: a 16-beat 64-bit instance and a 1-beat
// 32-bit instance driven from one linear stimulus sequence.
module tb_axi_burst_writer;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---------------- 16-beat, 64-bit instance ----------------
    logic        init = 0, awready = 0, wready = 0, bvalid = 0;
    logic [31:0] addr = 0;
    logic [63:0] wdata = 0;
    logic [1:0]  bresp = 0;
    logic        next, done, error, busy, awvalid, wlast, wvalid, bready;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic [63:0] wdata_o;
    logic [7:0]  wstrb;

    axi_burst_writer #(.DATA_WIDTH(64), .ADDRESS_WIDTH(32), .BURST_LEN(16)) dut_a (
        .clk(clk), .rst(rst),
        .write_init_i(init), .write_address_i(addr), .write_data_i(wdata),
        .write_next_o(next), .write_done_o(done), .write_error_o(error), .busy_o(busy),
        .m_axi_awaddr(awaddr), .m_axi_awlen(awlen), .m_axi_awsize(awsize),
        .m_axi_awburst(awburst), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
        .m_axi_wdata(wdata_o), .m_axi_wstrb(wstrb), .m_axi_wlast(wlast),
        .m_axi_wvalid(wvalid), .m_axi_wready(wready),
        .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready)
    );

    // ---------------- 1-beat, 32-bit instance ----------------
    logic        init_b = 0;
    logic [31:0] addr_b = 0;
    logic [31:0] wdata_b = 0;
    logic        next_b, done_b, error_b, busy_b, awvalid_b, wlast_b, wvalid_b, bready_b;
    logic [31:0] awaddr_b;
    logic [7:0]  awlen_b;
    logic [2:0]  awsize_b;
    logic [1:0]  awburst_b;
    logic [31:0] wdata_o_b;
    logic [3:0]  wstrb_b;

    axi_burst_writer #(.DATA_WIDTH(32), .ADDRESS_WIDTH(32), .BURST_LEN(1)) dut_b (
        .clk(clk), .rst(rst),
        .write_init_i(init_b), .write_address_i(addr_b), .write_data_i(wdata_b),
        .write_next_o(next_b), .write_done_o(done_b), .write_error_o(error_b), .busy_o(busy_b),
        .m_axi_awaddr(awaddr_b), .m_axi_awlen(awlen_b), .m_axi_awsize(awsize_b),
        .m_axi_awburst(awburst_b), .m_axi_awvalid(awvalid_b), .m_axi_awready(1'b1),
        .m_axi_wdata(wdata_o_b), .m_axi_wstrb(wstrb_b), .m_axi_wlast(wlast_b),
        .m_axi_wvalid(wvalid_b), .m_axi_wready(1'b1),
        .m_axi_bresp(2'b00), .m_axi_bvalid(1'b1), .m_axi_bready(bready_b)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_awaddr"}, awaddr, 0);
        check({tag, "_awvalid"}, awvalid, 0);
        check({tag, "_wvalid"}, wvalid, 0);
        check({tag, "_bready"}, bready, 0);
        check({tag, "_next"}, next, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_error"}, error, 0);
        check({tag, "_busy"}, busy, 0);
    endtask

    // Present an init in IDLE; the FSM must still be idle during this cycle.
    task automatic start_burst(input logic [31:0] a);
        @(negedge clk);
        init = 1'b1;
        addr = a;
        #1;
        check("start_busy", busy, 0);
        check("start_awvalid", awvalid, 0);
    endtask

    // Full-speed slave from the AW cycle through done. ghost_beat >= 0 pulses a
    // stray init during that beat; chain issues the next init in the done cycle.
    task automatic finish_burst(input logic [31:0] exp_addr, input logic [1:0] resp,
                                input int ghost_beat, input bit chain,
                                input logic [31:0] chain_addr);
        logic [63:0] beat_data;
        awready = 1'b1;
        wready  = 1'b1;
        bvalid  = 1'b1;
        bresp   = resp;
        @(negedge clk);
        init = 1'b0;
        #1;
        check("aw_valid", awvalid, 1);
        check("aw_addr", awaddr, {32'd0, exp_addr});
        check("aw_len", awlen, 15);
        check("aw_size", awsize, 3);
        check("aw_burst", awburst, 1);
        check("aw_wvalid_low", wvalid, 0);
        check("aw_busy", busy, 1);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            init = (i == ghost_beat);
            addr = 32'hDEAD_0000;
            beat_data = 64'h0123_4567_0000_0000 + 64'(i);
            wdata = beat_data;
            #1;
            check("w_valid", wvalid, 1);
            check("w_next", next, 1);
            check("w_data", wdata_o, beat_data);
            check("w_strb", wstrb, 8'hFF);
            check("w_last", wlast, (i == 15));
            check("w_awvalid_low", awvalid, 0);
        end
        @(negedge clk);
        init = 1'b0;
        #1;
        check("b_ready", bready, 1);
        check("b_wvalid_low", wvalid, 0);
        check("b_done_low", done, 0);
        @(negedge clk);
        if (chain) begin
            init = 1'b1;
            addr = chain_addr;
        end
        #1;
        check("done_pulse", done, 1);
        check("done_error", error, (resp != 2'b00));
        check("done_busy", busy, 0);
        check("done_bready", bready, 0);
        check("done_awaddr", awaddr, {32'd0, exp_addr});
        if (!chain) begin
            @(negedge clk);
            #1;
            check("post_done", done, 0);
            check("post_error", error, 0);
            check("post_busy", busy, 0);
            check("post_awvalid", awvalid, 0);
        end
    endtask

    initial begin
        int  beat_idx;
        int  rx;
        bit  seen_done;
        bit  aw_seen;
        bit  prev_aw_pend;
        bit  prev_w_pend;
        bit  prev_b_pend;

        // Reset
        repeat (2) @(negedge clk);
        #1;
        check_all_zero("reset");
        check("reset_busy_b", busy_b, 0);
        @(negedge clk);
        rst = 1'b1;

        // Full-speed burst with all READYs high
        start_burst(32'h1000_0000);
        finish_burst(32'h1000_0000, 2'b00, -1, 1'b0, 32'h0);

        // Random backpressure; core model advances data only on write_next
        start_burst(32'h1000_0400);
        beat_idx = 0; rx = 0; seen_done = 0; aw_seen = 0;
        prev_aw_pend = 0; prev_w_pend = 0; prev_b_pend = 0;
        for (int c = 0; c < 600 && !seen_done; c++) begin
            @(negedge clk);
            init    = 1'b0;
            awready = 1'($urandom_range(0, 1));
            wready  = 1'($urandom_range(0, 1));
            bvalid  = 1'($urandom_range(0, 1));
            bresp   = 2'b00;
            wdata   = 64'(beat_idx);
            #1;
            if (prev_aw_pend) check("rnd_awvalid_hold", awvalid, 1);
            if (prev_w_pend)  check("rnd_wvalid_hold", wvalid, 1);
            if (prev_b_pend)  check("rnd_bready_hold", bready, 1);
            if (awvalid && awready) begin
                check("rnd_awaddr", awaddr, 64'h1000_0400);
                aw_seen = 1;
            end
            if (wvalid) check("rnd_aw_before_w", aw_seen, 1);
            if (wvalid && wready) begin
                check("rnd_wdata", wdata_o, 64'(rx));
                check("rnd_wlast", wlast, (rx == 15));
                rx++;
            end
            if (next) beat_idx++;
            if (done) begin
                seen_done = 1;
                check("rnd_error", error, 0);
                check("rnd_busy", busy, 0);
            end
            prev_aw_pend = awvalid && !awready;
            prev_w_pend  = wvalid && !wready;
            prev_b_pend  = bready && !bvalid;
        end
        check("rnd_finished", seen_done, 1);
        check("rnd_beats_rx", 64'(rx), 16);
        check("rnd_next_count", 64'(beat_idx), 16);

        // SLVERR response, stray init during DATA, then chained init in done cycle
        start_burst(32'h1000_0800);
        finish_burst(32'h1000_0800, 2'b10, 5, 1'b1, 32'h2000_0000);
        finish_burst(32'h2000_0000, 2'b00, -1, 1'b0, 32'h0);

        // Reset asserted during beat 7 abandons the burst
        start_burst(32'h3000_0000);
        @(negedge clk);
        init = 1'b0;
        #1;
        check("rst_aw_valid", awvalid, 1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            wdata = 64'(i);
            if (i == 7) rst = 1'b0;
            #1;
            check("rst_beat_next", next, 1);
        end
        @(negedge clk);
        #1;
        check_all_zero("midrst");
        rst = 1'b1;
        start_burst(32'h3000_0080);
        finish_burst(32'h3000_0080, 2'b00, -1, 1'b0, 32'h0);

        // BURST_LEN=1 instance
        @(negedge clk);
        init_b = 1'b1;
        addr_b = 32'h0000_0040;
        #1;
        check("b1_idle", busy_b, 0);
        @(negedge clk);
        init_b = 1'b0;
        #1;
        check("b1_awvalid", awvalid_b, 1);
        check("b1_awaddr", awaddr_b, 32'h40);
        check("b1_awlen", awlen_b, 0);
        check("b1_awsize", awsize_b, 2);
        check("b1_awburst", awburst_b, 1);
        @(negedge clk);
        wdata_b = 32'h1234_5678;
        #1;
        check("b1_wvalid", wvalid_b, 1);
        check("b1_wlast", wlast_b, 1);
        check("b1_next", next_b, 1);
        check("b1_wdata", wdata_o_b, 32'h1234_5678);
        check("b1_wstrb", wstrb_b, 4'hF);
        @(negedge clk);
        #1;
        check("b1_bready", bready_b, 1);
        check("b1_wvalid_low", wvalid_b, 0);
        @(negedge clk);
        #1;
        check("b1_done", done_b, 1);
        check("b1_error", error_b, 0);
        @(negedge clk);
        #1;
        check("b1_done_low", done_b, 0);
        check("b1_busy_low", busy_b, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_burst_writer.md
# axi_burst_writer

AXI4 full-protocol write master for the upsampling IP's output path. It sits directly downstream of the IP core's simple write port: it accepts the core's `write_init`/`write_address`/`write_data` request, issues one fixed-length INCR burst on the AW/W/B channels, and returns the per-beat `write_next` and end-of-burst `write_done` indications the core consumes.

## Interface
Parameters:
- `DATA_WIDTH`, 64: W-channel and core data width in bits; must be a power of two, ≥ 8.
- `ADDRESS_WIDTH`, 32: address width.
- `BURST_LEN`, 16: beats per burst, 1..256.

Ports:
- `clk`  in  1  sole clock.
- `rst`  in  1  synchronous, active-low reset.
- `write_init_i`  in  1  single-cycle burst request from the core.
- `write_address_i`  in  ADDRESS_WIDTH  burst start byte address, sampled with `write_init_i`.
- `write_data_i`  in  DATA_WIDTH  current beat data, held by the core until `write_next_o`.
- `write_next_o`  out  1  current beat accepted; the core presents the next beat from the following cycle.
- `write_done_o`  out  1  one-cycle pulse at burst completion.
- `write_error_o`  out  1  qualifies `write_done_o`; high when BRESP ≠ OKAY.
- `busy_o`  out  1  high whenever state ≠ IDLE.
- `m_axi_awaddr`  out  ADDRESS_WIDTH  burst address.
- `m_axi_awlen`  out  8  BURST_LEN−1, constant.
- `m_axi_awsize`  out  3  log2(DATA_WIDTH/8), constant.
- `m_axi_awburst`  out  2  2'b01 (INCR), constant.
- `m_axi_awvalid`  out  1  / `m_axi_awready`  in  1
- `m_axi_wdata`  out  DATA_WIDTH  equals `write_data_i` combinationally.
- `m_axi_wstrb`  out  DATA_WIDTH/8  all ones.
- `m_axi_wlast`  out  1  final beat marker.
- `m_axi_wvalid`  out  1  / `m_axi_wready`  in  1
- `m_axi_bresp`  in  2  / `m_axi_bvalid`  in  1  / `m_axi_bready`  out  1

## Operation
- FSM with four states: IDLE → ADDR → DATA → RESP → IDLE.
- IDLE: on `write_init_i`, register `write_address_i` into `m_axi_awaddr`, clear the beat counter, and go to ADDR. Otherwise `write_init_i` is ignored in every state except IDLE; no queuing.
- ADDR: `m_axi_awvalid`=1. On `awvalid && awready`, go to DATA. AW is always issued before any W beat.
- DATA: `m_axi_wvalid`=1. Each W handshake increments the 8-bit beat counter.
  - `write_next_o` = `wvalid && wready` (combinational).
  - `m_axi_wlast` = (count == BURST_LEN−1) && DATA.
  - The handshake on the last beat moves the FSM to RESP.
- RESP: `m_axi_bready`=1. On `bvalid`, register `write_done_o`=1 and `write_error_o`=(bresp≠2'b00) for exactly one cycle, and go to IDLE.
- Addresses must be aligned to BURST_LEN·DATA_WIDTH/8; the caller guarantees this, which also guarantees no 4 KB crossing. The writer does not modify the address.
- VALID signals are registered state decodes and never drop before their handshake, as AXI requires.

## Timing
- Reset (`rst`=0 at a clock edge) forces the following, regardless of current state:
  - state IDLE, counter 0;
  - `m_axi_awaddr`=0, `awvalid`=`wvalid`=`bready`=0;
  - `write_next_o`=`write_done_o`=`write_error_o`=`busy_o`=0.
- Reset mid-burst abandons the transaction; the interconnect must be reset together with the writer.
- Minimum latency with all READY/BVALID asserted as early as possible:
  - init accepted at cycle 0;
  - `awvalid` high at cycle 1;
  - W beats at cycles 2..BURST_LEN+1;
  - `bready` high from cycle BURST_LEN+2;
  - `write_done_o` at the cycle after the B handshake.
- `write_done_o` is asserted while the FSM is in IDLE, so an init in that same cycle is accepted: back-to-back bursts.
- `wready` low stalls DATA with `wvalid` held high, `wdata` stable, and `write_next_o`=0.
- A `bvalid` that arrives before RESP is not consumed until RESP is reached.
- BURST_LEN=1: `wlast` is high on the single beat.

## Structure
- Shared package `upsampling_axi_pkg` holds:
  - `axi_wr_state_t` enum {IDLE, ADDR, DATA, RESP};
  - constants `AXI_BURST_INCR`=2'b01, `AXI_RESP_OKAY`=2'b00, `AXI_RESP_SLVERR`=2'b10.
- Single module; no sub-module. The beat counter and FSM are inline.

## Test plan
- BURST_LEN=16, all READY high, init with address 0x1000_0000 → AWADDR=0x1000_0000, AWLEN=15, AWSIZE=3, 16 W beats on consecutive cycles, `wlast` only on beat 16, 16 `write_next_o` pulses, `write_done_o` one cycle after B, `write_error_o`=0.
- Random `awready`/`wready`/`bvalid` backpressure (~50%), data beats 0..15 → AXI slave model receives exactly 0..15 in order, VALIDs never drop before handshake, `write_next_o` count = 16.
- BRESP=2'b10 → `write_done_o`=1 with `write_error_o`=1 for one cycle, then IDLE.
- Second init during DATA, then init in the `write_done_o` cycle → first extra init ignored, second starts a new burst (AWVALID next cycle).
- `rst`=0 asserted at beat 7 → next cycle all outputs 0, `busy_o`=0; a new init after reset yields a clean 16-beat burst.
- BURST_LEN=1 build → AWLEN=0, a single beat with `wlast`=1, done after B.
